stepper_move_ctrl: RTL

STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

---
 rtl/stepper_move_ctrl_if.sv | 29 ++
 rtl/stepper_move_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/stepper_move_ctrl_if.sv
// Command/status bundle between a motion controller and one stepper move engine.
// The master side issues moves; the slave side (the engine) reports step activity and position.
interface stepper_move_ctrl_if #(
  parameter int POS_W = 16,
  parameter int PER_W = 16
);
  logic             start;
  logic [15:0]      count;
  logic             move_dir;
  logic [PER_W-1:0] period;
  logic             abort;
  logic             zero_pos;
  logic             step;
  logic             dir;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] position;
  logic [15:0]      steps_left;

  modport master (
    output start, count, move_dir, period, abort, zero_pos,
    input  step, dir, busy, done, position, steps_left
  );

  modport slave (
    input  start, count, move_dir, period, abort, zero_pos,
    output step, dir, busy, done, position, steps_left
  );
endinterface

// File: rtl/stepper_move_ctrl.sv
// Stepper move engine: issues N evenly spaced step pulses, tracks signed position,
// and supports abort and position zeroing.
module stepper_move_ctrl #(
  parameter int POS_W = 16,
  parameter int PER_W = 16
) (
  input logic               clock,
  input logic               reset,
  stepper_move_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, next_state;
  logic             accept, fire;
  logic [PER_W-1:0] eff_period;
  logic [PER_W-1:0] per_q, tmr_q;
  logic [15:0]      left_q;
  logic             step_q, dir_q, done_q;
  logic [POS_W-1:0] pos_q;

  assign eff_period = (bus.period == '0) ? PER_W'(1) : bus.period;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    accept     = 1'b0;
    fire       = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          accept     = 1'b1;
          next_state = (bus.count == 16'd0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (tmr_q == PER_W'(1)) begin
          fire = 1'b1;
          if (left_q == 16'd1) next_state = FINISH;
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      per_q  <= '0;
      tmr_q  <= '0;
      left_q <= '0;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      pos_q  <= '0;
    end else begin
      step_q <= fire;
      done_q <= (state == FINISH) && !bus.abort;

      // Timer counts down from the period; the edge where it reads 1 issues a step.
      if (accept) begin
        dir_q  <= bus.move_dir;
        per_q  <= eff_period;
        tmr_q  <= eff_period;
        left_q <= bus.count;
      end else if (state != IDLE && bus.abort) begin
        tmr_q  <= '0;
        left_q <= '0;
      end else if (fire) begin
        tmr_q  <= per_q;
        left_q <= left_q - 16'd1;
      end else if (state == RUN) begin
        tmr_q  <= tmr_q - PER_W'(1);
      end

      if (bus.zero_pos)  pos_q <= '0;
      else if (fire)     pos_q <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.step       = step_q;
    bus.dir        = dir_q;
    bus.done       = done_q;
    bus.position   = pos_q;
    bus.steps_left = left_q;
  end

endmodule
